// File: rtl/fdd_track_loader_if.sv
// SD block request/acknowledge bundle between the track loader and the SD harness.
// One request/ack pair and one LBA word per drive.
interface fdd_track_loader_if #(
    parameter int DRIVES = 2,
    parameter int LBA_W  = 32
);
    logic [DRIVES*LBA_W-1:0] sd_lba;
    logic [DRIVES-1:0]       sd_rd;
    logic [DRIVES-1:0]       sd_wr;
    logic [DRIVES-1:0]       sd_ack;

    modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
    modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/fdd_track_loader.sv
// Multi-drive floppy track cache: writes back dirty sectors, then streams a whole
// track from the SD image into the track buffer whenever a drive needs service.
//
// state | meaning
// IDLE  | no transfer; pick lowest-index drive needing service
// WB    | writing dirty sectors of the cached track back to SD
// RD    | reading sectors 0..SECS_PER_TRACK-1 of the latched track
module fdd_track_loader #(
    parameter int DRIVES         = 2,
    parameter int SECS_PER_TRACK = 13,
    parameter int TRACK_BITS     = 6,
    parameter int LBA_W          = 32
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic [DRIVES*TRACK_BITS-1:0] track,
    input  logic [DRIVES-1:0]            img_mounted,
    input  logic [DRIVES-1:0]            img_present,
    input  logic [DRIVES-1:0]            img_readonly,
    input  logic                         fd_sec_dirty,
    input  logic [1:0]                   fd_sec_drive,
    input  logic [3:0]                   fd_sec_idx,
    fdd_track_loader_if.master           sd,
    output logic [1:0]                   buf_drive,
    output logic [3:0]                   track_sec,
    output logic                         cpu_wait,
    output logic [DRIVES-1:0]            busy
);
    typedef enum logic [1:0] {S_IDLE, S_WB, S_RD} state_t;

    state_t                                 state_q, state_d;
    logic [1:0]                             drv_q, drv_d;
    logic [3:0]                             sec_q, sec_d;
    logic                                   req_q, req_d;
    logic [TRACK_BITS-1:0]                  tgt_q, tgt_d;
    logic [DRIVES-1:0]                      ack_prev_q, ack_prev_d;
    logic [DRIVES-1:0][TRACK_BITS-1:0]      cur_track_q, cur_track_d;
    logic [DRIVES-1:0]                      loaded_q, loaded_d;
    logic [DRIVES-1:0]                      remount_q, remount_d;
    logic [DRIVES-1:0][SECS_PER_TRACK-1:0]  dirty_q, dirty_d;

    logic [DRIVES-1:0]         need;
    logic                      win_found, win_loaded, win_ro;
    logic [1:0]                win;
    logic [TRACK_BITS-1:0]     win_track, act_cur, lba_trk;
    logic [SECS_PER_TRACK-1:0] win_dirty, next_mask;
    logic                      act_present, act_ack, act_prev, ack_rise, ack_fall;
    logic                      go_wb, wb_fall, rd_done, drop;
    logic [LBA_W-1:0]          lba_act;

    function automatic logic [3:0] lowest(input logic [SECS_PER_TRACK-1:0] m);
        logic [3:0] r;
        r = '0;
        for (int i = SECS_PER_TRACK - 1; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            drv_q       <= '0;
            sec_q       <= '0;
            req_q       <= 1'b0;
            tgt_q       <= '0;
            ack_prev_q  <= '0;
            cur_track_q <= '0;
            loaded_q    <= '0;
            remount_q   <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            drv_q       <= drv_d;
            sec_q       <= sec_d;
            req_q       <= req_d;
            tgt_q       <= tgt_d;
            ack_prev_q  <= ack_prev_d;
            cur_track_q <= cur_track_d;
            loaded_q    <= loaded_d;
            remount_q   <= remount_d;
            dirty_q     <= dirty_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drv_d       = drv_q;
        sec_d       = sec_q;
        req_d       = req_q;
        tgt_d       = tgt_q;
        ack_prev_d  = sd.sd_ack;
        cur_track_d = cur_track_q;
        loaded_d    = loaded_q;
        remount_d   = remount_q;
        dirty_d     = dirty_q;
        need        = '0;
        win_found   = 1'b0;
        win         = '0;
        win_track   = '0;
        win_dirty   = '0;
        win_loaded  = 1'b0;
        win_ro      = 1'b0;
        act_present = 1'b0;
        act_ack     = 1'b0;
        act_prev    = 1'b0;
        act_cur     = '0;
        next_mask   = '0;
        go_wb       = 1'b0;
        wb_fall     = 1'b0;
        rd_done     = 1'b0;
        drop        = 1'b0;

        // Descending scan so the lowest-index drive needing service ends up as winner.
        for (int d = DRIVES - 1; d >= 0; d--) begin
            need[d] = img_present[d] && (!loaded_q[d] || remount_q[d] ||
                      (track[d*TRACK_BITS +: TRACK_BITS] != cur_track_q[d]));
            if (need[d]) begin
                win_found  = 1'b1;
                win        = 2'(d);
                win_track  = track[d*TRACK_BITS +: TRACK_BITS];
                win_dirty  = dirty_q[d];
                win_loaded = loaded_q[d];
                win_ro     = img_readonly[d];
            end
            if (drv_q == 2'(d)) begin
                act_present = img_present[d];
                act_ack     = sd.sd_ack[d];
                act_prev    = ack_prev_q[d];
                act_cur     = cur_track_q[d];
            end
        end
        ack_rise = act_ack && !act_prev;
        ack_fall = !act_ack && act_prev;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    drv_d   = win;
                    tgt_d   = win_track;
                    req_d   = 1'b1;
                    go_wb   = (win_dirty != '0) && win_loaded && !win_ro;
                    state_d = go_wb ? S_WB : S_RD;
                    sec_d   = go_wb ? lowest(win_dirty) : 4'd0;
                end
            end
            S_WB, S_RD: begin
                if (ack_rise) req_d = 1'b0;
                if (ack_fall) begin
                    if (!act_present) begin
                        state_d = S_IDLE;
                        drop    = 1'b1;
                    end else if (state_q == S_WB) begin
                        wb_fall = 1'b1;
                    end else if (sec_q == 4'(SECS_PER_TRACK - 1)) begin
                        state_d = S_IDLE;
                        rd_done = 1'b1;
                    end else begin
                        sec_d = sec_q + 4'd1;
                        req_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Order matters: write-back clear, then new dirty pulse, then mount clear.
        for (int d = 0; d < DRIVES; d++) begin
            if (state_q == S_IDLE && win_found && win == 2'(d)) begin
                remount_d[d] = 1'b0;
                if (!go_wb) dirty_d[d] = '0;
            end
            if (wb_fall && drv_q == 2'(d)) begin
                for (int s = 0; s < SECS_PER_TRACK; s++) begin
                    if (sec_q == 4'(s)) dirty_d[d][s] = 1'b0;
                end
            end
            if (fd_sec_dirty && fd_sec_drive == 2'(d)) begin
                for (int s = 0; s < SECS_PER_TRACK; s++) begin
                    if (fd_sec_idx == 4'(s)) dirty_d[d][s] = 1'b1;
                end
            end
            if (img_mounted[d]) begin
                dirty_d[d]   = '0;
                remount_d[d] = 1'b1;
            end
            if (drv_q == 2'(d)) begin
                if (rd_done) begin
                    loaded_d[d]    = 1'b1;
                    cur_track_d[d] = tgt_q;
                end
                if (drop) loaded_d[d] = 1'b0;
                next_mask = dirty_d[d];
            end
        end

        if (wb_fall) begin
            req_d = 1'b1;
            if (next_mask == '0) begin
                state_d = S_RD;
                sec_d   = '0;
            end else begin
                sec_d = lowest(next_mask);
            end
        end
    end

    always_comb begin
        sd.sd_lba = '0;
        sd.sd_rd  = '0;
        sd.sd_wr  = '0;
        busy      = '0;
        lba_trk   = (state_q == S_WB) ? act_cur : tgt_q;
        lba_act   = LBA_W'(SECS_PER_TRACK) * LBA_W'(lba_trk) + LBA_W'(sec_q);
        for (int d = 0; d < DRIVES; d++) begin
            if (state_q != S_IDLE && drv_q == 2'(d)) begin
                busy[d]                      = 1'b1;
                sd.sd_lba[d*LBA_W +: LBA_W]  = lba_act;
                sd.sd_rd[d]                  = req_q && (state_q == S_RD);
                sd.sd_wr[d]                  = req_q && (state_q == S_WB);
            end
        end
    end

    assign cpu_wait  = (state_q != S_IDLE);
    assign buf_drive = drv_q;
    assign track_sec = sec_q;
endmodule

// File: tb/tb_fdd_track_loader.sv
// Directed bench for fdd_track_loader: an SD ack model pops expected requests from a
// scoreboard filled by the stimulus sequence and checks every handshake.
module tb_fdd_track_loader;
    localparam int DRIVES = 2;
    localparam int SECS   = 13;
    localparam int TB     = 6;
    localparam int LW     = 32;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    logic [DRIVES*TB-1:0] track;
    logic [DRIVES-1:0]    img_mounted, img_present, img_readonly;
    logic                 fd_sec_dirty;
    logic [1:0]           fd_sec_drive;
    logic [3:0]           fd_sec_idx;
    logic [1:0]           buf_drive;
    logic [3:0]           track_sec;
    logic                 cpu_wait;
    logic [DRIVES-1:0]    busy;

    fdd_track_loader_if #(.DRIVES(DRIVES), .LBA_W(LW)) sd_if ();

    fdd_track_loader #(
        .DRIVES(DRIVES), .SECS_PER_TRACK(SECS), .TRACK_BITS(TB), .LBA_W(LW)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .track(track),
        .img_mounted(img_mounted), .img_present(img_present), .img_readonly(img_readonly),
        .fd_sec_dirty(fd_sec_dirty), .fd_sec_drive(fd_sec_drive), .fd_sec_idx(fd_sec_idx),
        .sd(sd_if), .buf_drive(buf_drive), .track_sec(track_sec),
        .cpu_wait(cpu_wait), .busy(busy)
    );

    typedef struct {
        bit wr;
        int drv;
        int lba;
        int sec;
        bit last;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   phase = 0;
    int   cnt = 0;
    int   cur = 0;
    bit   e_last = 0;
    bit   last_pend = 0;
    bit   expect_next = 0;
    logic [LW-1:0]     cur_lba;
    logic [DRIVES-1:0] req;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] lba_of(input int d);
        return sd_if.sd_lba[d*LW +: LW];
    endfunction

    task automatic push_track(input int d, input int t);
        for (int s = 0; s < SECS; s++)
            sb.push_back('{wr: 1'b0, drv: d, lba: SECS*t + s, sec: s, last: (s == SECS-1)});
    endtask

    task automatic push_wr(input int d, input int t, input int s);
        sb.push_back('{wr: 1'b1, drv: d, lba: SECS*t + s, sec: s, last: 1'b0});
    endtask

    task automatic set_track(input int d, input int t);
        track[d*TB +: TB] = TB'(t);
    endtask

    task automatic dirty_pulse(input int d, input int s);
        @(negedge clk_sys);
        fd_sec_dirty = 1'b1;
        fd_sec_drive = 2'(d);
        fd_sec_idx   = 4'(s);
        @(negedge clk_sys);
        fd_sec_dirty = 1'b0;
    endtask

    task automatic mount_pulse(input int d);
        @(negedge clk_sys);
        img_mounted[d] = 1'b1;
        @(negedge clk_sys);
        img_mounted = '0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk_sys);
            #1;
            if (sb.size() == 0 && phase == 0 && !cpu_wait && !last_pend) done = 1'b1;
        end
        check(tag, {63'b0, done}, 64'd1);
        repeat (4) @(negedge clk_sys);
    endtask

    // SD ack model: acks each request one cycle after it is seen, for 4 cycles.
    initial begin
        sd_if.sd_ack = '0;
        forever begin
            @(negedge clk_sys);
            req = sd_if.sd_rd | sd_if.sd_wr;
            if (reset) begin
                sd_if.sd_ack = '0;
                phase        = 0;
                last_pend    = 1'b0;
                expect_next  = 1'b0;
            end else if (phase == 0) begin
                if (req != '0) begin
                    cur = 0;
                    for (int d = DRIVES - 1; d >= 0; d--) if (req[d]) cur = d;
                    e_last = 1'b0;
                    if (sb.size() == 0) begin
                        check("unexpected_req", {62'b0, req}, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        e_last = e.last;
                        check("sd_rd", {62'b0, sd_if.sd_rd}, e.wr ? 64'd0 : 64'd1 << e.drv);
                        check("sd_wr", {62'b0, sd_if.sd_wr}, e.wr ? 64'd1 << e.drv : 64'd0);
                        check("sd_lba", {32'b0, lba_of(e.drv)}, 64'(e.lba));
                        check("track_sec", {60'b0, track_sec}, 64'(e.sec));
                        check("buf_drive", {62'b0, buf_drive}, 64'(e.drv));
                        check("busy", {62'b0, busy}, 64'd1 << e.drv);
                        check("cpu_wait_req", {63'b0, cpu_wait}, 64'd1);
                    end
                    cur_lba     = lba_of(cur);
                    phase       = 1;
                    expect_next = 1'b0;
                end else begin
                    if (expect_next) begin
                        check("next_req_gap", {63'b0, |req}, 64'd1);
                        expect_next = 1'b0;
                    end
                    if (last_pend) begin
                        check("end_cpu_wait", {63'b0, cpu_wait}, 64'd0);
                        last_pend = 1'b0;
                    end
                end
            end else if (phase == 1) begin
                sd_if.sd_ack[cur] = 1'b1;
                phase = 2;
                cnt   = 4;
            end else begin
                if (cnt == 4) check("req_drop", {63'b0, req[cur]}, 64'd0);
                check("lba_stable", {32'b0, lba_of(cur)}, {32'b0, cur_lba});
                check("cpu_wait_hold", {63'b0, cpu_wait}, 64'd1);
                cnt--;
                if (cnt == 0) begin
                    sd_if.sd_ack[cur] = 1'b0;
                    phase = 0;
                    if (e_last) last_pend = 1'b1;
                    else expect_next = 1'b1;
                end
            end
        end
    end

    initial begin
        bit found;
        track        = '0;
        img_mounted  = '0;
        img_present  = '0;
        img_readonly = '0;
        fd_sec_dirty = 1'b0;
        fd_sec_drive = '0;
        fd_sec_idx   = '0;
        set_track(1, 2);

        #12;
        check("rst_sd_rd", {62'b0, sd_if.sd_rd}, 64'd0);
        check("rst_sd_wr", {62'b0, sd_if.sd_wr}, 64'd0);
        check("rst_cpu_wait", {63'b0, cpu_wait}, 64'd0);
        check("rst_busy", {62'b0, busy}, 64'd0);
        check("rst_track_sec", {60'b0, track_sec}, 64'd0);
        check("rst_buf_drive", {62'b0, buf_drive}, 64'd0);
        check("rst_sd_lba", sd_if.sd_lba, 64'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("idle_no_present", {63'b0, cpu_wait}, 64'd0);

        // Cold load of drive 0, track 0, with first-request latency.
        push_track(0, 0);
        img_present[0] = 1'b1;
        #1;
        check("cold_idle_before", {63'b0, cpu_wait}, 64'd0);
        @(posedge clk_sys);
        #1;
        check("first_req_latency", {62'b0, sd_if.sd_rd}, 64'd1);
        check("first_cpu_wait", {63'b0, cpu_wait}, 64'd1);
        wait_done("cold_load_done", 400);
        repeat (10) @(negedge clk_sys);
        check("loaded_stays_idle", {63'b0, cpu_wait}, 64'd0);

        // Step to track 3, dirty sectors 5 and 1, then step to 4 with write-back.
        push_track(0, 3);
        set_track(0, 3);
        wait_done("track3_done", 400);
        dirty_pulse(0, 5);
        dirty_pulse(0, 1);
        push_wr(0, 3, 1);
        push_wr(0, 3, 5);
        push_track(0, 4);
        @(negedge clk_sys);
        set_track(0, 4);
        wait_done("writeback_done", 500);

        // Readonly: dirty mask discarded, reads only.
        dirty_pulse(0, 5);
        dirty_pulse(0, 1);
        push_track(0, 5);
        @(negedge clk_sys);
        img_readonly[0] = 1'b1;
        set_track(0, 5);
        wait_done("readonly_done", 400);
        img_readonly[0] = 1'b0;

        // Out-of-range sector index and drive index are ignored; discarded mask stays empty.
        dirty_pulse(0, 13);
        dirty_pulse(3, 2);
        push_track(0, 6);
        @(negedge clk_sys);
        set_track(0, 6);
        wait_done("ignored_dirty_done", 400);

        // Arbitration: both drives need service in the same cycle.
        push_track(0, 7);
        push_track(1, 2);
        @(negedge clk_sys);
        set_track(0, 7);
        img_present[1] = 1'b1;
        wait_done("arbitration_done", 800);

        // Remount on drive 1 with unchanged track: reload without write-back.
        dirty_pulse(1, 3);
        push_track(1, 2);
        mount_pulse(1);
        wait_done("remount_done", 400);

        // Mount and dirty in the same cycle: mount wins.
        push_track(1, 2);
        @(negedge clk_sys);
        fd_sec_dirty   = 1'b1;
        fd_sec_drive   = 2'd1;
        fd_sec_idx     = 4'd4;
        img_mounted[1] = 1'b1;
        @(negedge clk_sys);
        fd_sec_dirty = 1'b0;
        img_mounted  = '0;
        wait_done("mount_dirty_done", 400);

        // Reset in the middle of a drive 1 sector.
        push_track(1, 2);
        mount_pulse(1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk_sys);
            #1;
            if (sd_if.sd_ack[1] && track_sec == 4'd2) found = 1'b1;
        end
        check("mid_sector_reached", {63'b0, found}, 64'd1);
        @(posedge clk_sys);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_sd_rd", {62'b0, sd_if.sd_rd}, 64'd0);
        check("rst_mid_cpu_wait", {63'b0, cpu_wait}, 64'd0);
        check("rst_mid_busy", {62'b0, busy}, 64'd0);
        @(negedge clk_sys);
        sb.delete();
        push_track(0, 7);
        push_track(1, 2);
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        wait_done("post_reset_reload_done", 800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
